// File: rtl/acc_pkg.sv
// Shared types and helpers for the accelerator request arbiter.
package acc_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width that stays at least one bit for single-entry structures.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_rr_lock_arb.sv
// Round-robin arbiter that locks onto its winner until that winner handshakes.
module acc_rr_lock_arb
    import acc_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = clog2_min1(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              issue_en_i,
    input  logic              hs_i,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_valid_o,
    output arb_state_e        state_o
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] rr_idx;
    logic            rr_found;
    int unsigned     cand;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid_o && !hs_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = gnt_idx_o;
                end
            end
            ARB_LOCKED: begin
                if (hs_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (hs_i) begin
            ptr_d = (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    // Winner: first requester at or after the pointer, unless locked.
    always_comb begin
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned o = 0; o < NumReq; o++) begin
            cand = 32'(ptr_q) + o;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!rr_found && req_i[IdxW'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = IdxW'(cand);
            end
        end
        state_o = state_q;
        if (state_q == ARB_LOCKED) begin
            gnt_idx_o   = lock_idx_q;
            gnt_valid_o = issue_en_i && req_i[lock_idx_q];
        end else begin
            gnt_idx_o   = rr_idx;
            gnt_valid_o = issue_en_i && rr_found;
        end
    end

    a_lock_holds_winner: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_IDLE && gnt_valid_o && !hs_i) |=> (gnt_idx_o == $past(gnt_idx_o)));

endmodule

// File: rtl/fifo_v3.sv
// Small synchronous FIFO; occupancy is tracked separately from the wrapping pointers.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is never reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/acc_req_arbiter.sv
// Shares one accelerator port between NumReq adapters; responses return in issue order.
module acc_req_arbiter
    import acc_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         acc_req_chan_t = logic,
    parameter type         acc_rsp_chan_t = logic,
    localparam int unsigned IdxW = clog2_min1(NumReq),
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic          [NumReq-1:0]   slv_q_valid_i,
    output logic          [NumReq-1:0]   slv_q_ready_o,
    input  acc_req_chan_t [NumReq-1:0]   slv_q_i,
    output logic          [NumReq-1:0]   slv_p_valid_o,
    input  logic          [NumReq-1:0]   slv_p_ready_i,
    output acc_rsp_chan_t                slv_p_o,
    output logic                         mst_q_valid_o,
    input  logic                         mst_q_ready_i,
    output acc_req_chan_t                mst_q_o,
    input  logic                         mst_p_valid_i,
    output logic                         mst_p_ready_o,
    input  acc_rsp_chan_t                mst_p_i,
    output logic          [CntW-1:0]     outstanding_o,
    output logic                         err_o
);

    localparam int unsigned FifoAw = clog2_min1(MaxOutstanding);

    logic [IdxW-1:0]   gnt_idx, head_idx;
    logic              gnt_valid, q_hs, p_hs;
    logic              fifo_full, fifo_empty;
    logic [FifoAw-1:0] fifo_usage;
    logic              err_q, err_d;
    arb_state_e        arb_state;

    acc_rr_lock_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (slv_q_valid_i),
        .issue_en_i  (!fifo_full),
        .hs_i        (q_hs),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .state_o     (arb_state)
    );

    // No bypass: a full FIFO blocks issue even if a response pops this cycle.
    fifo_v3 #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MaxOutstanding)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (gnt_idx),
        .push_i  (q_hs),
        .data_o  (head_idx),
        .pop_i   (p_hs)
    );

    always_comb begin
        mst_q_valid_o = gnt_valid && !rst_i;
        mst_q_o       = slv_q_i[gnt_idx];
        slv_q_ready_o = '0;
        if (gnt_valid && !rst_i) begin
            slv_q_ready_o[gnt_idx] = mst_q_ready_i;
        end
        slv_p_o       = mst_p_i;
        slv_p_valid_o = '0;
        mst_p_ready_o = 1'b0;
        if (!rst_i) begin
            if (fifo_empty) begin
                mst_p_ready_o = 1'b1;
            end else begin
                slv_p_valid_o[head_idx] = mst_p_valid_i;
                mst_p_ready_o           = slv_p_ready_i[head_idx];
            end
        end
        q_hs  = mst_q_valid_o && mst_q_ready_i;
        p_hs  = !fifo_empty && mst_p_valid_i && mst_p_ready_o;
        err_d = err_q || (!rst_i && fifo_empty && mst_p_valid_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o         = err_q;
    assign outstanding_o = fifo_full ? CntW'(MaxOutstanding) : CntW'(fifo_usage);

    a_q_ready_onehot: assert property (@(posedge clk_i) $onehot0(slv_q_ready_o));
    a_p_valid_onehot: assert property (@(posedge clk_i) $onehot0(slv_p_valid_o));
    a_lock_state_known: assert property (@(posedge clk_i) disable iff (rst_i)
        (arb_state == ARB_LOCKED) |-> mst_q_valid_o);
    a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        !$past(rst_i) |-> ((slv_q_valid_i & $past(slv_q_valid_i & ~slv_q_ready_o))
                           == $past(slv_q_valid_i & ~slv_q_ready_o)));

endmodule
